aes_shift_rows_pipe: RTL and testbench

- Parametrised, registered Rijndael ShiftRows / InvShiftRows unit for the AES encrypt and decrypt datapaths.
- Supports block widths Nb = 4, 6 or 8 columns. Direction is selectable per transaction.
- Valid/ready handshake with a 2-entry skid buffer, so it sustains one block per cycle under backpressure.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey pipeline stages.

---
 rtl/aes_shift_rows_pipe.sv | 171 +++++++++++++++++
 tb/tb_aes_shift_rows_pipe.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_pipe.sv
// Registered AES ShiftRows/InvShiftRows with a 2-entry skid buffer, NB = 4/6/8.
// Optional per-byte parity ports are enabled by defining AES_SHIFT_ROWS_PARITY_EN.
module aes_shift_rows_pipe #(
    parameter int NB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
`ifdef AES_SHIFT_ROWS_PARITY_EN
    input  logic [NB*4-1:0]   in_par,
    output logic [NB*4-1:0]   out_par,
    output logic              par_err,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_inv
);

    localparam int W  = 32 * NB;
    localparam int NP = NB * 4;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    function automatic int row_off(input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (NB == 8) return r + 1;
        return r;
    endfunction

    typedef struct packed {
        logic [W-1:0]  data;
        logic          inv;
`ifdef AES_SHIFT_ROWS_PARITY_EN
        logic [NP-1:0] par;
`endif
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    logic [W-1:0]  fwd_data;
    logic [W-1:0]  inv_data;
`ifdef AES_SHIFT_ROWS_PARITY_EN
    logic [NP-1:0] fwd_par;
    logic [NP-1:0] inv_par;
    logic [NP-1:0] par_bad;
`endif

    // Byte k = 4c+r sits at the MSB end; row r rotates by its own offset.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int K  = 4 * c + r;
            localparam int KF = 4 * ((c + row_off(r)) % NB) + r;
            localparam int KI = 4 * ((c - row_off(r) + NB) % NB) + r;
            assign fwd_data[W-1-8*K -: 8] = in_data[W-1-8*KF -: 8];
            assign inv_data[W-1-8*K -: 8] = in_data[W-1-8*KI -: 8];
`ifdef AES_SHIFT_ROWS_PARITY_EN
            assign fwd_par[NP-1-K] = in_par[NP-1-KF];
            assign inv_par[NP-1-K] = in_par[NP-1-KI];
            assign par_bad[K] = (^in_data[W-1-8*K -: 8]) ^ in_par[NP-1-K];
`endif
        end
    end

    beat_t  in_beat;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   acc, emit;
`ifdef AES_SHIFT_ROWS_PARITY_EN
    logic   par_err_q, par_err_d;
`endif

    always_comb begin
        in_beat      = '0;
        in_beat.data = in_inv ? inv_data : fwd_data;
        in_beat.inv  = in_inv;
`ifdef AES_SHIFT_ROWS_PARITY_EN
        in_beat.par  = in_inv ? inv_par : fwd_par;
`endif
    end

    assign acc  = in_valid && in_ready_q;
    assign emit = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_beat;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        main_d = in_beat;
                    end else if (acc) begin
                        skid_d  = in_beat;
                        state_d = FULL;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

`ifdef AES_SHIFT_ROWS_PARITY_EN
    assign par_err_d = acc && (|par_bad);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef AES_SHIFT_ROWS_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef AES_SHIFT_ROWS_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q.data;
    assign out_inv   = main_q.inv;
`ifdef AES_SHIFT_ROWS_PARITY_EN
    assign out_par   = main_q.par;
    assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: NB=4 and NB=8 instances.
// Parity checks are compiled in when AES_SHIFT_ROWS_PARITY_EN is defined.
module tb_aes_shift_rows_pipe;

    logic clk;
    logic rst_n;

    logic         flush, in_valid, in_ready, in_inv;
    logic         out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;

    logic         e_flush, e_in_valid, e_in_ready, e_in_inv;
    logic         e_out_valid, e_out_ready, e_out_inv;
    logic [255:0] e_in_data, e_out_data;

    int vectors;
    int miscompares;

    localparam logic [127:0] V4 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] F4 = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] I4 = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [255:0] V8 =
        256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] F8 =
        256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

`ifdef AES_SHIFT_ROWS_PARITY_EN
    logic [15:0] in_par, out_par, par_flip;
    logic [31:0] e_in_par, e_out_par;
    logic        par_err, e_par_err;

    function automatic logic [15:0] par4(input logic [127:0] d);
        logic [15:0] p;
        for (int k = 0; k < 16; k++) p[15-k] = ^d[127-8*k -: 8];
        return p;
    endfunction

    function automatic logic [31:0] par8(input logic [255:0] d);
        logic [31:0] p;
        for (int k = 0; k < 32; k++) p[31-k] = ^d[255-8*k -: 8];
        return p;
    endfunction

    assign in_par   = par4(in_data) ^ par_flip;
    assign e_in_par = par8(e_in_data);
`endif

    aes_shift_rows_pipe #(.NB(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
`ifdef AES_SHIFT_ROWS_PARITY_EN
        .in_par    (in_par),
        .out_par   (out_par),
        .par_err   (par_err),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv)
    );

    aes_shift_rows_pipe #(.NB(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (e_flush),
`ifdef AES_SHIFT_ROWS_PARITY_EN
        .in_par    (e_in_par),
        .out_par   (e_out_par),
        .par_err   (e_par_err),
`endif
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .in_data   (e_in_data),
        .in_inv    (e_in_inv),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready),
        .out_data  (e_out_data),
        .out_inv   (e_out_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat(input int i);
        logic [7:0] b;
        b = 8'(8'h10 * (i + 1));
        return {16{b}};
    endfunction

    task automatic test_reset();
        vectors += 5;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_ready got %b want 0", in_ready);
        end
        if (out_data !== 128'h0) begin
            miscompares++;
            $display("FAIL rst_out_data got %h want 0", out_data);
        end
        if (out_inv !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_out_inv got %b want 0", out_inv);
        end
        if (e_out_valid !== 1'b0 || e_out_data !== 256'h0) begin
            miscompares++;
            $display("FAIL rst_nb8 got v=%b d=%h want 0", e_out_valid, e_out_data);
        end
        #2 rst_n = 1'b1;
        tick();
        vectors += 3;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rel_in_ready got %b want 1", in_ready);
        end
        if (e_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rel_nb8_ready got %b want 1", e_in_ready);
        end
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rel_out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_dir(input logic inv, input logic [127:0] exp);
        in_valid  = 1'b1;
        in_data   = V4;
        in_inv    = inv;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors += 3;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL dir%0b_valid got %b want 1", inv, out_valid);
        end
        if (out_data !== exp) begin
            miscompares++;
            $display("FAIL dir%0b_data got %h want %h", inv, out_data, exp);
        end
        if (out_inv !== inv) begin
            miscompares++;
            $display("FAIL dir%0b_inv got %b want %b", inv, out_inv, inv);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL dir%0b_drain got %b want 0", inv, out_valid);
        end
    endtask

    task automatic test_nb8();
        logic [255:0] r, fw;
        e_out_ready = 1'b1;
        e_in_valid  = 1'b1;
        e_in_data   = V8;
        e_in_inv    = 1'b0;
        tick();
        vectors += 3;
        if (e_out_data !== F8) begin
            miscompares++;
            $display("FAIL nb8_fwd got %h want %h", e_out_data, F8);
        end
        if (e_out_data[255-24 -: 8] !== 8'h13 || e_out_data[255-16 -: 8] !== 8'h0e) begin
            miscompares++;
            $display("FAIL nb8_s30_s20 got %h %h want 13 0e",
                     e_out_data[255-24 -: 8], e_out_data[255-16 -: 8]);
        end
        e_in_data = F8;
        e_in_inv  = 1'b1;
        tick();
        if (e_out_data !== V8 || e_out_inv !== 1'b1) begin
            miscompares++;
            $display("FAIL nb8_inv got %h/%b want %h/1", e_out_data, e_out_inv, V8);
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        e_in_data = r;
        e_in_inv  = 1'b0;
        tick();
        fw = e_out_data;
        e_in_data = fw;
        e_in_inv  = 1'b1;
        tick();
        e_in_valid = 1'b0;
        vectors++;
        if (e_out_data !== r) begin
            miscompares++;
            $display("FAIL nb8_roundtrip got %h want %h", e_out_data, r);
        end
        tick();
    endtask

    task automatic test_back_to_back_stall();
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        in_data   = beat(0);
        out_ready = 1'b1;
        tick();
        in_data   = beat(1);
        out_ready = 1'b0;
        tick();
        vectors += 2;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_full_ready got %b want 0", in_ready);
        end
        if (out_data !== beat(0)) begin
            miscompares++;
            $display("FAIL stall_b0 got %h want %h", out_data, beat(0));
        end
        in_data = beat(2);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (out_data !== beat(0) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d got %h v=%b r=%b want %h v=1 r=0",
                         i, out_data, out_valid, in_ready, beat(0));
            end
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_data !== beat(1) || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_b1 got %h r=%b want %h r=1", out_data, in_ready, beat(1));
        end
        for (int i = 2; i < 5; i++) begin
            if (i > 2) in_data = beat(i);
            tick();
            vectors++;
            if (out_data !== beat(i) || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_b%0d got %h v=%b want %h", i, out_data, out_valid, beat(i));
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = beat(0);
        tick();
        in_data = beat(1);
        tick();
        flush   = 1'b1;
        in_data = beat(2);
        tick();
        vectors += 2;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_nothing got %b want 0", out_valid);
        end
        in_valid  = 1'b1;
        in_data   = beat(3);
        out_ready = 1'b0;
        tick();
        flush   = 1'b1;
        in_data = beat(4);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_one_acc got %b want 0", out_valid);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        in_valid  = 1'b1;
        in_data   = V4;
        in_inv    = 1'b1;
        out_ready = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors += 2;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || out_inv !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_out got v=%b d=%h i=%b want 0", out_valid, out_data, out_inv);
        end
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_in_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #3;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_pre_edge got %b want 0", in_ready);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_post_edge got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
    endtask

`ifdef AES_SHIFT_ROWS_PARITY_EN
    task automatic test_parity();
        in_valid  = 1'b1;
        in_data   = V4;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        par_flip  = 16'h0;
        tick();
        vectors += 2;
        if (par_err !== 1'b0) begin
            miscompares++;
            $display("FAIL par_clean got %b want 0", par_err);
        end
        if (out_par !== par4(F4)) begin
            miscompares++;
            $display("FAIL par_perm got %h want %h", out_par, par4(F4));
        end
        par_flip = 16'h0100;
        tick();
        par_flip = 16'h0;
        in_valid = 1'b0;
        vectors++;
        if (par_err !== 1'b1) begin
            miscompares++;
            $display("FAIL par_err_hi got %b want 1", par_err);
        end
        tick();
        vectors++;
        if (par_err !== 1'b0) begin
            miscompares++;
            $display("FAIL par_err_pulse got %b want 0", par_err);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_inv      = 1'b0;
        out_ready   = 1'b1;
        e_flush     = 1'b0;
        e_in_valid  = 1'b0;
        e_in_data   = '0;
        e_in_inv    = 1'b0;
        e_out_ready = 1'b1;
`ifdef AES_SHIFT_ROWS_PARITY_EN
        par_flip    = 16'h0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_dir(1'b0, F4);
        test_dir(1'b1, I4);
        test_nb8();
        test_back_to_back_stall();
        test_flush();
        test_async_reset();
`ifdef AES_SHIFT_ROWS_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
